// File: rtl/bn_share_arbiter_pkg.sv
// Shared types and sizing for the batchnorm share arbiter: widths, tag record, FSM states.
package bn_pkg;

    localparam int unsigned DEF_WIDTH    = 16;
    localparam int unsigned DEF_CHANNELS = 48;
    localparam int unsigned DEF_NREQ     = 2;
    localparam int unsigned DEF_BN_LAT   = 5;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned CW         = idx_width(DEF_CHANNELS);
    localparam int unsigned IW         = idx_width(DEF_NREQ);
    localparam int unsigned WARMUP_CYC = DEF_CHANNELS + 3;
    localparam int unsigned WCW        = idx_width(WARMUP_CYC);

    typedef struct packed {
        logic          v;
        logic          oob;
        logic [IW-1:0] id;
        logic [CW-1:0] ch;
    } bn_tag_t;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        IDLE   = 2'd1,
        BUSY   = 2'd2
    } bn_state_e;

    // Round-robin successor, wrapping at NREQ (not necessarily a power of two).
    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] id);
        return (32'(id) >= DEF_NREQ - 1) ? '0 : id + 1'b1;
    endfunction

    function automatic logic [DEF_NREQ-1:0] onehot(input logic [IW-1:0] id);
        logic [DEF_NREQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bn_share_arbiter_if.sv
// Requester-side bundle: per-requester beat handshake plus the shared result return.
interface bn_share_arbiter_if
    import bn_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [DEF_NREQ-1:0]       req_valid;
    logic [DEF_NREQ-1:0]       req_ready;
    logic [DEF_NREQ*WIDTH-1:0] req_data;
    logic [DEF_NREQ*CW-1:0]    req_ch;
    logic [DEF_NREQ-1:0]       req_last;
    logic [DEF_NREQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]          rsp_data;
    logic [CW-1:0]             rsp_ch;

    modport master (
        output req_valid, req_data, req_ch, req_last,
        input  req_ready, rsp_valid, rsp_data, rsp_ch
    );

    modport slave (
        input  req_valid, req_data, req_ch, req_last,
        output req_ready, rsp_valid, rsp_data, rsp_ch
    );
endinterface

// File: rtl/bn_share_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, as one-hot plus index.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_c,
    output logic [IW-1:0]   gnt_id_c,
    output logic            any_c
);

    always_comb begin
        int unsigned idx;
        idx      = 0;
        gnt_c    = '0;
        gnt_id_c = '0;
        any_c    = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_c && req_i[IW'(idx)]) begin
                any_c             = 1'b1;
                gnt_c[IW'(idx)]   = 1'b1;
                gnt_id_c          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/bn_share_arbiter.sv
// Shares one fixed-latency batchnorm between requesters: packet-locked round-robin issue,
// tagged in-flight tracking and routed result return.
module bn_share_arbiter
    import bn_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BN_LAT = DEF_BN_LAT
) (
    input  logic              clk,
    input  logic              rst,
    bn_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]  bn_x,
    output logic [CW-1:0]     bn_ch,
    output logic              bn_valid,
    output logic              bn_en,
    input  logic [WIDTH-1:0]  bn_y,
    input  logic [CW-1:0]     bn_ch_out,
    input  logic              bn_vout,
    output logic              busy,
    output logic              tag_err
);

    bn_state_e           state_q, state_d;
    logic [WCW-1:0]      warm_q, warm_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [IW-1:0]       lock_q, lock_d;
    bn_tag_t             pipe_q [BN_LAT+1];
    bn_tag_t             head;

    logic [DEF_NREQ-1:0] gnt_c;
    logic [IW-1:0]       gnt_id_c;
    logic                any_c;
    logic [DEF_NREQ-1:0] ready_c;
    logic [IW-1:0]       win_id_c;
    logic                xfer_c;
    logic [WIDTH-1:0]    beat_data_c;
    logic [CW-1:0]       beat_ch_c;
    logic                oob_c;
    logic                tag_mis_c;

    rr_arbiter #(
        .NREQ (DEF_NREQ),
        .IW   (IW)
    ) u_rr (
        .req_i    (bus.req_valid),
        .ptr_i    (rr_q),
        .gnt_c    (gnt_c),
        .gnt_id_c (gnt_id_c),
        .any_c    (any_c)
    );

    // Next-state, grant and round-robin pointer update.
    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        rr_d     = rr_q;
        lock_d   = lock_q;
        ready_c  = '0;
        win_id_c = gnt_id_c;
        case (state_q)
            WARMUP: begin
                if (warm_q == WCW'(WARMUP_CYC - 1)) state_d = IDLE;
                else                                 warm_d  = warm_q + 1'b1;
            end
            IDLE: begin
                ready_c  = gnt_c;
                win_id_c = gnt_id_c;
                if (any_c) begin
                    if (bus.req_last[gnt_id_c]) begin
                        rr_d = rr_next(gnt_id_c);
                    end else begin
                        state_d = BUSY;
                        lock_d  = gnt_id_c;
                    end
                end
            end
            BUSY: begin
                // Lock holds across valid gaps until the packet's last beat.
                ready_c  = onehot(lock_q);
                win_id_c = lock_q;
                if (bus.req_valid[lock_q] && bus.req_last[lock_q]) begin
                    state_d = IDLE;
                    rr_d    = rr_next(lock_q);
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    always_comb begin
        bus.req_ready = ready_c;
        xfer_c        = |(ready_c & bus.req_valid);
        beat_data_c   = bus.req_data[32'(win_id_c)*WIDTH +: WIDTH];
        beat_ch_c     = bus.req_ch[32'(win_id_c)*CW +: CW];
        oob_c         = 32'(beat_ch_c) >= DEF_CHANNELS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WARMUP;
            warm_q  <= '0;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    // Issue register; out-of-range channels never reach the batchnorm.
    always_ff @(posedge clk) begin
        if (rst) begin
            bn_x     <= '0;
            bn_ch    <= '0;
            bn_valid <= 1'b0;
            bn_en    <= 1'b0;
        end else begin
            bn_valid <= xfer_c & ~oob_c;
            bn_en    <= (state_d != WARMUP);
            if (xfer_c && !oob_c) begin
                bn_x  <= beat_data_c;
                bn_ch <= beat_ch_c;
            end
        end
    end

    // Tag pipe is one entry longer than BN_LAT to cover the issue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= BN_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= '{v: xfer_c, oob: xfer_c & oob_c, id: win_id_c, ch: beat_ch_c};
            for (int unsigned i = 1; i <= BN_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign head = pipe_q[BN_LAT];

    always_comb begin
        tag_mis_c = 1'b0;
        if (!head.oob) tag_mis_c = (head.v != bn_vout) || (head.v && (bn_ch_out != head.ch));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_ch    <= '0;
            tag_err       <= 1'b0;
        end else begin
            bus.rsp_valid <= head.v ? onehot(head.id) : '0;
            if (head.v) begin
                bus.rsp_data <= head.oob ? '0 : bn_y;
                bus.rsp_ch   <= head.ch;
            end
            if (tag_mis_c) tag_err <= 1'b1;
        end
    end

    always_comb begin
        busy = (state_q == BUSY);
        for (int unsigned i = 0; i <= BN_LAT; i++) busy = busy | pipe_q[i].v;
    end

endmodule

// File: tb/tb_bn_share_arbiter.sv
// Directed bench for bn_share_arbiter with a 5-cycle batchnorm stand-in (y = x ^ 16'hA5A5).
module tb_bn_share_arbiter;
    import bn_pkg::*;

    localparam int unsigned W = DEF_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bn_share_arbiter_if #(.WIDTH(W)) bus ();

    logic [W-1:0]  bn_x, bn_y;
    logic [CW-1:0] bn_ch, bn_ch_out;
    logic          bn_valid, bn_en, bn_vout, busy, tag_err;
    logic          inj = 1'b0;

    bn_share_arbiter #(.WIDTH(W), .BN_LAT(DEF_BN_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .bn_x      (bn_x),
        .bn_ch     (bn_ch),
        .bn_valid  (bn_valid),
        .bn_en     (bn_en),
        .bn_y      (bn_y),
        .bn_ch_out (bn_ch_out),
        .bn_vout   (bn_vout),
        .busy      (busy),
        .tag_err   (tag_err)
    );

    // Batchnorm stand-in: valid_in in cycle c gives valid_out in cycle c+5.
    logic [4:0]    bv_q;
    logic [W-1:0]  by_q [5];
    logic [CW-1:0] bc_q [5];
    always @(posedge clk) begin
        if (rst) begin
            bv_q <= '0;
            for (int i = 0; i < 5; i++) begin by_q[i] <= '0; bc_q[i] <= '0; end
        end else begin
            bv_q    <= {bv_q[3:0], bn_valid & bn_en};
            by_q[0] <= bn_x ^ 16'hA5A5;
            bc_q[0] <= bn_ch;
            for (int i = 1; i < 5; i++) begin by_q[i] <= by_q[i-1]; bc_q[i] <= bc_q[i-1]; end
        end
    end
    assign bn_vout   = bv_q[4] | inj;
    assign bn_y      = by_q[4];
    assign bn_ch_out = bc_q[4];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int                  due;
        logic [DEF_NREQ-1:0] id_oh;
        logic [W-1:0]        data;
        logic [CW-1:0]       ch;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input int lat, input logic [DEF_NREQ-1:0] oh,
                            input logic [W-1:0] d, input logic [CW-1:0] ch);
        exp_t e;
        e.due = cyc + lat; e.id_oh = oh; e.data = d; e.ch = ch;
        sb.push_back(e);
    endtask

    // Response monitor: each expected result must appear exactly at its due cycle.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rsp_valid", 32'(bus.rsp_valid), 32'(sb[0].id_oh));
                check("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
                check("rsp_ch", 32'(bus.rsp_ch), 32'(sb[0].ch));
                void'(sb.pop_front());
            end else if (bus.rsp_valid != '0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        inj = 1'b0;
        bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.req_ch = '0;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [1:0] l;
        int         ch0;
        int         ch1;
        logic [1:0] rdy;
        logic       bnv;
    } vec_t;
    vec_t tbl [16];

    initial begin
        int first;
        int pulses;
        int k;
        tbl[0]  = '{2'b11, 2'b00,  0, 10, 2'b01, 1'b1};
        tbl[1]  = '{2'b11, 2'b00,  1, 11, 2'b01, 1'b1};
        tbl[2]  = '{2'b11, 2'b00,  2, 12, 2'b01, 1'b1};
        tbl[3]  = '{2'b11, 2'b01,  3, 13, 2'b01, 1'b1};
        tbl[4]  = '{2'b11, 2'b00,  4, 14, 2'b10, 1'b1};
        tbl[5]  = '{2'b11, 2'b00,  5, 15, 2'b10, 1'b1};
        tbl[6]  = '{2'b11, 2'b00,  6, 16, 2'b10, 1'b1};
        tbl[7]  = '{2'b11, 2'b10,  7, 17, 2'b10, 1'b1};
        tbl[8]  = '{2'b10, 2'b00,  8, 18, 2'b10, 1'b1};
        tbl[9]  = '{2'b01, 2'b00,  9, 19, 2'b10, 1'b0};
        tbl[10] = '{2'b01, 2'b00, 10, 20, 2'b10, 1'b0};
        tbl[11] = '{2'b01, 2'b00, 11, 21, 2'b10, 1'b0};
        tbl[12] = '{2'b11, 2'b10, 12, 22, 2'b10, 1'b1};
        tbl[13] = '{2'b01, 2'b01, 13, 23, 2'b01, 1'b1};
        tbl[14] = '{2'b01, 2'b01, 50, 24, 2'b01, 1'b0};
        tbl[15] = '{2'b00, 2'b00,  0,  0, 2'b00, 1'b0};

        // Reset values, then warm-up hold-off and first-beat latency.
        do_reset();
        check("rst_bn_en", 32'(bn_en), 32'h0);
        check("rst_bn_valid", 32'(bn_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_tag_err", 32'(tag_err), 32'h0);
        bus.req_valid = 2'b01; bus.req_last = 2'b01;
        bus.req_data = {16'h0000, 16'h0100}; bus.req_ch = {CW'(0), CW'(3)};
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        first = -1;
        for (int c = 0; c < 200; c++) begin
            if (bus.req_ready[0]) begin first = c; break; end
            tick();
        end
        check("first_ready_cycle", 32'(first), 32'd51);
        check("bn_en_after_warmup", 32'(bn_en), 32'h1);
        if (first >= 0) push_exp(7, 2'b01, 16'hA4A5, CW'(3));
        tick();
        bus.req_valid = '0;
        check("issue_bn_valid", 32'(bn_valid), 32'h1);
        check("issue_bn_x", 32'(bn_x), 32'h0100);
        check("issue_bn_ch", 32'(bn_ch), 32'h3);
        repeat (8) tick();
        check("t1_rsp_drained", 32'(sb.size()), 32'h0);

        // Concurrent packets, locked gap, out-of-range channel.
        do_reset();
        repeat (51) tick();
        for (int r = 0; r < 16; r++) begin
            logic [1:0] acc;
            logic [W-1:0] d;
            int ch;
            bus.req_valid = tbl[r].v;
            bus.req_last  = tbl[r].l;
            bus.req_data  = {W'(32'h2000 + r), W'(32'h1000 + r)};
            bus.req_ch    = {CW'(tbl[r].ch1), CW'(tbl[r].ch0)};
            #1;
            check($sformatf("ready_row%0d", r), 32'(bus.req_ready), 32'(tbl[r].rdy));
            acc = tbl[r].v & tbl[r].rdy;
            if (acc != 2'b00) begin
                d  = acc[1] ? W'(32'h2000 + r) : W'(32'h1000 + r);
                ch = acc[1] ? tbl[r].ch1 : tbl[r].ch0;
                push_exp(7, acc, (ch >= 48) ? W'(0) : (d ^ 16'hA5A5), CW'(ch));
            end
            tick();
            check($sformatf("bn_valid_row%0d", r), 32'(bn_valid), 32'(tbl[r].bnv));
        end
        bus.req_valid = '0;
        repeat (9) tick();
        check("tbl_tag_err", 32'(tag_err), 32'h0);
        check("tbl_rsp_drained", 32'(sb.size()), 32'h0);
        check("tbl_busy_idle", 32'(busy), 32'h0);

        // Reset with three beats in flight.
        bus.req_last = 2'b01; bus.req_ch = {CW'(0), CW'(7)};
        for (int r = 0; r < 3; r++) begin
            bus.req_valid = 2'b01;
            bus.req_data  = {16'h0000, W'(32'h3000 + r)};
            #1;
            check($sformatf("inflight_ready%0d", r), 32'(bus.req_ready), 32'h1);
            tick();
        end
        bus.req_valid = '0;
        #1;
        check("inflight_busy", 32'(busy), 32'h1);
        sb.delete();
        do_reset();
        bus.req_valid = 2'b01; bus.req_last = 2'b01;
        bus.req_data = {16'h0000, 16'h0042}; bus.req_ch = {CW'(0), CW'(5)};
        #1;
        check("rerst_busy", 32'(busy), 32'h0);
        check("rerst_ready", 32'(bus.req_ready), 32'h0);
        check("rerst_bn_en", 32'(bn_en), 32'h0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.rsp_valid != '0) pulses++;
        end
        check("rsp_after_rst", 32'(pulses), 32'h0);
        check("rerst_warmup_ready", 32'(bus.req_ready), 32'h0);

        // Re-warm, then spurious early valid_out raises a sticky tag_err.
        k = 12;
        while (!bus.req_ready[0] && k < 200) begin tick(); k++; end
        check("rewarm_ready_cycle", 32'(k), 32'd51);
        push_exp(7, 2'b01, 16'hA5E7, CW'(5));
        tick();
        bus.req_valid = '0;
        repeat (4) tick();
        check("tag_err_pre", 32'(tag_err), 32'h0);
        inj = 1'b1;
        tick();
        inj = 1'b0;
        check("tag_err_set", 32'(tag_err), 32'h1);
        repeat (6) tick();
        check("tag_err_sticky", 32'(tag_err), 32'h1);
        check("t6_rsp_drained", 32'(sb.size()), 32'h0);
        do_reset();
        #1;
        check("tag_err_cleared", 32'(tag_err), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (checks=%0d)", checks);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
